// File: rtl/win_scan_ctrl.sv
// Sequential five-in-a-row detector for the gobang board. It walks the four lines
// through the last move one cell per cycle and feeds a single shared run counter.
module win_scan_ctrl #(
    parameter int BOARD_N = 15,
    parameter int WIN_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [3:0]                   row,
    input  logic [3:0]                   col,
    input  logic [BOARD_N*BOARD_N-1:0]   ch,
    output logic                         busy,
    output logic                         done,
    output logic                         win,
    output logic [1:0]                   win_dir,
    output logic                         err
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int RUN_W = $clog2(WIN_LEN + 1);
    localparam logic signed [5:0] K_MIN   = 6'(1 - WIN_LEN);
    localparam logic signed [5:0] K_MAX   = 6'(WIN_LEN - 1);
    localparam logic signed [5:0] N_S     = 6'(BOARD_N);
    localparam logic [RUN_W-1:0]  RUN_WIN = RUN_W'(WIN_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic [CELLS-1:0]   ch_q, ch_d;
    logic [1:0]         dir_q, dir_d;
    logic signed [5:0]  k_q, k_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               win_q, win_d;
    logic [1:0]         win_dir_q, win_dir_d;
    logic               err_q, err_d;

    logic signed [5:0]  step_r, step_c;
    logic signed [5:0]  cell_r, cell_c;
    logic               cell_in;
    logic [IDX_W-1:0]   cell_idx;
    logic               stone;
    logic [RUN_W-1:0]   run_inc;
    logic               coord_ok;

    assign coord_ok = ({1'b0, row} < 5'(BOARD_N)) && ({1'b0, col} < 5'(BOARD_N));

    // Cell currently under examination; anything off the board reads as empty.
    always_comb begin
        step_r = (dir_q == 2'd0) ? 6'sd0 : k_q;
        case (dir_q)
            2'd0:    step_c = k_q;
            2'd1:    step_c = 6'sd0;
            2'd2:    step_c = k_q;
            default: step_c = -k_q;
        endcase
        cell_r   = $signed({2'b00, row_q}) + step_r;
        cell_c   = $signed({2'b00, col_q}) + step_c;
        cell_in  = (cell_r >= 6'sd0) && (cell_r < N_S) &&
                   (cell_c >= 6'sd0) && (cell_c < N_S);
        cell_idx = cell_in ? (IDX_W'(cell_r[3:0]) * IDX_W'(BOARD_N) + IDX_W'(cell_c[3:0]))
                           : '0;
        stone    = cell_in && ch_q[cell_idx];
        run_inc  = (run_q >= RUN_WIN) ? run_q : run_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        ch_d      = ch_q;
        dir_d     = dir_q;
        k_d       = k_q;
        run_d     = run_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        win_d     = win_q;
        win_dir_d = win_dir_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    win_d     = 1'b0;
                    win_dir_d = 2'd0;
                    if (coord_ok) begin
                        row_d   = row;
                        col_d   = col;
                        ch_d    = ch;
                        err_d   = 1'b0;
                        run_d   = '0;
                        dir_d   = 2'd0;
                        k_d     = K_MIN;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            SCAN: begin
                run_d = stone ? run_inc : '0;
                if (stone && (run_inc == RUN_WIN)) begin
                    win_d     = 1'b1;
                    win_dir_d = dir_q;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else if (k_q == K_MAX) begin
                    // Runs never carry from one direction into the next.
                    run_d = '0;
                    k_d   = K_MIN;
                    if (dir_q == 2'd3) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        dir_d = dir_q + 2'd1;
                    end
                end else begin
                    k_d = k_q + 6'sd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            ch_q      <= '0;
            dir_q     <= '0;
            k_q       <= '0;
            run_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            win_dir_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ch_q      <= ch_d;
            dir_q     <= dir_d;
            k_q       <= k_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            win_q     <= win_d;
            win_dir_q <= win_dir_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign win     = win_q;
    assign win_dir = win_dir_q;
    assign err     = err_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Bench for win_scan_ctrl: directed vector table, hand-written control sequences
// and random boards checked against a line-walking reference model.
module tb_win_scan_ctrl;

    localparam int N     = 15;
    localparam int W     = 5;
    localparam int CELLS = N * N;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       row;
    logic [3:0]       col;
    logic [CELLS-1:0] ch;
    logic             busy;
    logic             done;
    logic             win;
    logic [1:0]       win_dir;
    logic             err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [CELLS-1:0] board;
        int               r;
        int               c;
        int               exp_lat;
        int               exp_win;
        int               exp_dir;
        int               exp_err;
        string            name;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    win_scan_ctrl #(.BOARD_N(N), .WIN_LEN(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .row     (row),
        .col     (col),
        .ch      (ch),
        .busy    (busy),
        .done    (done),
        .win     (win),
        .win_dir (win_dir),
        .err     (err)
    );

    function automatic logic [CELLS-1:0] line_bits(input int r, input int c,
                                                   input int dr, input int dc, input int n);
        logic [CELLS-1:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[(r + i * dr) * N + (c + i * dc)] = 1'b1;
        return b;
    endfunction

    function automatic logic [CELLS-1:0] rand_board(input int pct);
        logic [CELLS-1:0] b;
        for (int i = 0; i < CELLS; i++) b[i] = ($urandom_range(99) < pct);
        return b;
    endfunction

    function automatic vec_t mk(input logic [CELLS-1:0] b, input int r, input int c,
                                input int lat, input int w, input int d, input int e,
                                input string name);
        vec_t v;
        v.board = b; v.r = r; v.c = c; v.exp_lat = lat;
        v.exp_win = w; v.exp_dir = d; v.exp_err = e; v.name = name;
        return v;
    endfunction

    // Reference: walk each line through the move, counting consecutive stones.
    function automatic void model(input logic [CELLS-1:0] b, input int r, input int c,
                                  output int lat, output int w, output int d, output int e);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        int run, rr, cc;
        w = 0; d = 0; e = 0; lat = 1 + 4 * (2 * W - 1);
        if (r >= N || c >= N) begin
            e = 1; lat = 1;
            return;
        end
        for (int di = 0; di < 4; di++) begin
            run = 0;
            for (int k = -(W - 1); k <= W - 1; k++) begin
                rr = r + k * dr[di];
                cc = c + k * dc[di];
                if (rr >= 0 && rr < N && cc >= 0 && cc < N && b[rr * N + cc]) run++;
                else run = 0;
                if (run >= W) begin
                    w = 1; d = di;
                    lat = di * (2 * W - 1) + (k + W - 1) + 2;
                    return;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Pulses start and follows the scan until done; done cycle is returned relative to T.
    task automatic applyStimulus(input logic [CELLS-1:0] b, input int r, input int c,
                                 input bit scramble, output int lat,
                                 output int busy_bad, output int pulse_bad);
        @(negedge clk);
        ch = b; row = 4'(r); col = 4'(c); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; busy_bad = 0; pulse_bad = 0;
        for (int j = 1; j <= 60 && lat < 0; j++) begin
            if (j > 1) @(negedge clk);
            if (scramble && j == 2) ch = rand_board(50);
            if (done) begin
                lat = j;
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            if (done) pulse_bad++;
        end
    endtask

    task automatic run_and_compare(input vec_t v, input bit scramble);
        int lat, busy_bad, pulse_bad;
        applyStimulus(v.board, v.r, v.c, scramble, lat, busy_bad, pulse_bad);
        checkOutput({v.name, "_done_cycle"}, lat, v.exp_lat);
        checkOutput({v.name, "_busy"}, busy_bad, 0);
        checkOutput({v.name, "_done_pulse"}, pulse_bad, 0);
        checkOutput({v.name, "_win"}, int'(win), v.exp_win);
        checkOutput({v.name, "_win_dir"}, int'(win_dir), v.exp_dir);
        checkOutput({v.name, "_err"}, int'(err), v.exp_err);
    endtask

    initial begin
        vec_t rv;
        logic [CELLS-1:0] rb;
        int rr, rc, lat, w, d, e, done_at, extra_done;

        rst = 1'b1; start = 1'b0; row = '0; col = '0; ch = '0;
        #12;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_win", int'(win), 0);
        checkOutput("reset_win_dir", int'(win_dir), 0);
        checkOutput("reset_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = mk(line_bits(7, 3, 0, 1, 5), 7, 5, 8, 1, 0, 0, "horiz");
        vecs[1] = mk(line_bits(10, 0, 1, 0, 5), 14, 0, 15, 1, 1, 0, "vert_edge");
        vecs[2] = mk(line_bits(3, 3, 1, 1, 5), 5, 5, 26, 1, 2, 0, "diag");
        vecs[3] = mk(line_bits(2, 6, 1, -1, 5), 4, 4, 35, 1, 3, 0, "anti_diag");
        vecs[4] = mk(line_bits(7, 3, 0, 1, 4) | line_bits(7, 8, 0, 1, 1), 7, 5, 37, 0, 0, 0, "broken");
        vecs[5] = mk('0, 15, 3, 1, 0, 0, 1, "bad_row");
        vecs[6] = mk(line_bits(0, 0, 0, 1, 6), 0, 2, 8, 1, 0, 0, "overline");
        vecs[7] = mk(line_bits(0, 0, 0, 1, 5), 3, 15, 1, 0, 0, 1, "bad_col");

        for (int i = 0; i < 8; i++) run_and_compare(vecs[i], 1'b0);

        // A second start at T+3 with a different board must be ignored.
        @(negedge clk);
        ch = line_bits(7, 3, 0, 1, 5); row = 4'd7; col = 4'd5; start = 1'b1;
        done_at = -1; extra_done = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 3) begin
                ch = '0; row = 4'd0; col = 4'd0; start = 1'b1;
            end
            if (done) begin
                if (done_at < 0) done_at = cyc;
                else extra_done++;
            end
        end
        start = 1'b0;
        checkOutput("restart_done_cycle", done_at, 8);
        checkOutput("restart_extra_done", extra_done, 0);
        checkOutput("restart_win", int'(win), 1);
        checkOutput("restart_win_dir", int'(win_dir), 0);

        // Reset at T+10 of a long scan aborts it without a done pulse.
        @(negedge clk);
        ch = line_bits(2, 6, 1, -1, 5); row = 4'd4; col = 4'd4; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        checkOutput("abort_no_done", extra_done, 0);
        checkOutput("abort_win", int'(win), 0);

        // Random boards against the reference model; ch is scrambled mid-scan.
        for (int t = 0; t < 60; t++) begin
            rb = rand_board(55 + int'($urandom_range(20)));
            rr = ($urandom_range(15) == 0) ? 15 : int'($urandom_range(N - 1));
            rc = ($urandom_range(15) == 0) ? 15 : int'($urandom_range(N - 1));
            if (rr < N && rc < N) rb[rr * N + rc] = 1'b1;
            model(rb, rr, rc, lat, w, d, e);
            rv = mk(rb, rr, rc, lat, w, d, e, $sformatf("rand%0d", t));
            run_and_compare(rv, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
